// File: rtl/sensores_pkg.sv
// Shared sensor-pair encodings, FSM states and pair-validation helpers.
// Pump controllers reuse the same encodings.
package sensores_pkg;

    localparam logic [1:0] VAZIO      = 2'b00;
    localparam logic [1:0] PARCIAL    = 2'b01;
    localparam logic [1:0] CHEIO      = 2'b11;
    localparam logic [1:0] IMPOSSIVEL = 2'b10;

    localparam int N_DEBOUNCE_DEF = 4;
    localparam int W_FALHAS_DEF   = 8;

    typedef enum logic [1:0] {
        INICIAL = 2'd0,
        NORMAL  = 2'd1,
        FALHA   = 2'd2
    } estado_t;

    // Both bits changing at once (00<->11) cannot happen with a real level.
    function automatic logic salto_ilegal(
        input logic [1:0] a,
        input logic [1:0] b
    );
        return (a ^ b) == 2'b11;
    endfunction

    // Pair is acceptable as a new output given the last valid pair.
    function automatic logic par_aceito(
        input logic [1:0] ultimo,
        input logic [1:0] novo
    );
        return (novo != IMPOSSIVEL) && !salto_ilegal(ultimo, novo);
    endfunction

endpackage

// File: rtl/debounce_par.sv
// Two-flop synchroniser plus pair debouncer for the s1/s2 level sensors.
// Ports: clk, rst_n, i_s1_raw, i_s2_raw, i_inicial (FSM in INICIAL),
//        o_committed (last accepted pair), o_cand (pair being accepted),
//        o_commit (one-cycle pulse, o_cand is loaded on this edge).
module debounce_par
    import sensores_pkg::*;
#(
    parameter int N_DEBOUNCE = N_DEBOUNCE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_s1_raw,
    input  logic       i_s2_raw,
    input  logic       i_inicial,
    output logic [1:0] o_committed,
    output logic [1:0] o_cand,
    output logic       o_commit
);

    localparam logic [3:0] CNT_FIM = 4'(N_DEBOUNCE - 1);

    logic       r_s1_meta;
    logic       r_s1_sync;
    logic       r_s2_meta;
    logic       r_s2_sync;
    logic [1:0] r_cand;
    logic [3:0] r_cnt;
    logic [1:0] r_committed;

    logic [1:0] w_sync;
    logic       w_commit_ok;
    logic       w_commit;

    assign w_sync = {r_s2_sync, r_s1_sync};

    // In INICIAL the first stable pair must commit even if it equals
    // the reset value of committed.
    assign w_commit_ok = (r_cand != r_committed) || i_inicial;

    assign w_commit = (w_sync == r_cand) && w_commit_ok
                      && (r_cnt == CNT_FIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_meta   <= 1'b0;
            r_s1_sync   <= 1'b0;
            r_s2_meta   <= 1'b0;
            r_s2_sync   <= 1'b0;
            r_cand      <= 2'b00;
            r_cnt       <= 4'd0;
            r_committed <= 2'b00;
        end else begin
            r_s1_meta <= i_s1_raw;
            r_s1_sync <= r_s1_meta;
            r_s2_meta <= i_s2_raw;
            r_s2_sync <= r_s2_meta;
            if (w_sync != r_cand) begin
                r_cand <= w_sync;
                r_cnt  <= 4'd0;
            end else if (w_commit) begin
                r_committed <= r_cand;
                r_cnt       <= 4'd0;
            end else if (w_commit_ok) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end
        end
    end

    assign o_committed = r_committed;
    assign o_cand      = r_cand;
    assign o_commit    = w_commit;

endmodule

// File: rtl/filtro_sensores.sv
// Sensor conditioning for one tank: debounced s1/s2, validity, alarm and
// a saturating count of NORMAL->FALHA entries.
// Ports: clk, rst_n (async, active-low), s1_raw, s2_raw, reconhece (ack pulse),
//        s1, s2, valido, alarme, contador_falhas[W_FALHAS-1:0].
// Build option: ALARME_TRAVADO_EN latches the alarm until reconhece.
module filtro_sensores
    import sensores_pkg::*;
#(
    parameter int N_DEBOUNCE = N_DEBOUNCE_DEF,
    parameter int W_FALHAS   = W_FALHAS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s1_raw,
    input  logic                s2_raw,
    input  logic                reconhece,
    output logic                s1,
    output logic                s2,
    output logic                valido,
    output logic                alarme,
    output logic [W_FALHAS-1:0] contador_falhas
);

    estado_t             r_estado;
    logic                r_s1;
    logic                r_s2;
    logic                r_valido;
    logic                r_alarme;
    logic [W_FALHAS-1:0] r_cont;

    logic [1:0] w_committed;
    logic [1:0] w_cand;
    logic       w_commit;
    logic [1:0] w_ultimo;
    logic       w_cand_ok;

    debounce_par #(
        .N_DEBOUNCE (N_DEBOUNCE)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_s1_raw    (s1_raw),
        .i_s2_raw    (s2_raw),
        .i_inicial   (r_estado == INICIAL),
        .o_committed (w_committed),
        .o_cand      (w_cand),
        .o_commit    (w_commit)
    );

    // Jump checks always use the last valid pair, never a faulty one.
    assign w_ultimo  = {r_s2, r_s1};
    assign w_cand_ok = par_aceito(w_ultimo, w_cand);

`ifdef ALARME_TRAVADO_EN
    logic [1:0] w_par_ack;
    logic       w_ack_ok;

    // A commit on the ack edge is evaluated first and wins.
    assign w_par_ack = w_commit ? w_cand : w_committed;
    assign w_ack_ok  = reconhece && par_aceito(w_ultimo, w_par_ack);
`else
    logic w_unused;
    assign w_unused = reconhece ^ (^w_committed);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= INICIAL;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_valido <= 1'b0;
            r_alarme <= 1'b0;
            r_cont   <= '0;
        end else begin
            unique case (r_estado)
                INICIAL: begin
                    if (w_commit) begin
                        if (w_cand == IMPOSSIVEL) begin
                            r_estado <= FALHA;
                            r_alarme <= 1'b1;
                        end else begin
                            r_estado <= NORMAL;
                            r_valido <= 1'b1;
                            r_s1     <= w_cand[0];
                            r_s2     <= w_cand[1];
                        end
                    end
                end
                NORMAL: begin
                    if (w_commit) begin
                        if (!w_cand_ok) begin
                            r_estado <= FALHA;
                            r_valido <= 1'b0;
                            r_alarme <= 1'b1;
                            if (r_cont != '1)
                                r_cont <= r_cont + 1'b1;
                        end else begin
                            r_s1 <= w_cand[0];
                            r_s2 <= w_cand[1];
                        end
                    end
                end
                FALHA: begin
`ifdef ALARME_TRAVADO_EN
                    if (w_ack_ok) begin
                        r_estado <= NORMAL;
                        r_valido <= 1'b1;
                        r_alarme <= 1'b0;
                        r_s1     <= w_par_ack[0];
                        r_s2     <= w_par_ack[1];
                    end
`else
                    if (w_commit && w_cand_ok) begin
                        r_estado <= NORMAL;
                        r_valido <= 1'b1;
                        r_alarme <= 1'b0;
                        r_s1     <= w_cand[0];
                        r_s2     <= w_cand[1];
                    end
`endif
                end
                default: begin
                    r_estado <= INICIAL;
                end
            endcase
        end
    end

    assign s1              = r_s1;
    assign s2              = r_s2;
    assign valido          = r_valido;
    assign alarme          = r_alarme;
    assign contador_falhas = r_cont;

endmodule

// File: tb/tb_filtro_sensores.sv
// Directed testbench for filtro_sensores (N_DEBOUNCE=4, W_FALHAS=8).
// Honours ALARME_TRAVADO_EN when defined for the build.
module tb_filtro_sensores;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s1_raw;
    logic       s2_raw;
    logic       reconhece;
    logic       s1;
    logic       s2;
    logic       valido;
    logic       alarme;
    logic [7:0] contador_falhas;

    int checks   = 0;
    int failures = 0;

    filtro_sensores #(
        .N_DEBOUNCE (4),
        .W_FALHAS   (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s1_raw          (s1_raw),
        .s2_raw          (s2_raw),
        .reconhece       (reconhece),
        .s1              (s1),
        .s2              (s2),
        .valido          (valido),
        .alarme          (alarme),
        .contador_falhas (contador_falhas)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic [1:0] p);
        rst_n = 1'b0;
        reconhece = 1'b0;
        {s2_raw, s1_raw} = p;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_raw(input logic [1:0] p);
        @(negedge clk);
        {s2_raw, s1_raw} = p;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        reconhece = 1'b1;
        @(negedge clk);
        reconhece = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        reconhece = 1'b0;
        s1_raw = 1'b0;
        s2_raw = 1'b0;
        #1;
        checks++; if (s1 !== 1'b0) begin failures++; $display("FAIL reset_s1 got=%b exp=0", s1); end
        checks++; if (s2 !== 1'b0) begin failures++; $display("FAIL reset_s2 got=%b exp=0", s2); end
        checks++; if (valido !== 1'b0) begin failures++; $display("FAIL reset_valido got=%b exp=0", valido); end
        checks++; if (alarme !== 1'b0) begin failures++; $display("FAIL reset_alarme got=%b exp=0", alarme); end
        checks++; if (contador_falhas !== 8'd0) begin failures++; $display("FAIL reset_cont got=%0d exp=0", contador_falhas); end
    endtask

    task automatic test_startup();
        do_reset(2'b01);
        wait_edges(6);
        checks++; if (valido !== 1'b0) begin failures++; $display("FAIL start_early_valido got=%b exp=0", valido); end
        wait_edges(1);
        checks++; if (valido !== 1'b1) begin failures++; $display("FAIL start_valido got=%b exp=1", valido); end
        checks++; if ({s2, s1} !== 2'b01) begin failures++; $display("FAIL start_pair got=%b exp=01", {s2, s1}); end
        checks++; if (alarme !== 1'b0) begin failures++; $display("FAIL start_alarme got=%b exp=0", alarme); end
    endtask

    task automatic test_glitch();
        set_raw(2'b11);
        repeat (4) @(negedge clk);
        {s2_raw, s1_raw} = 2'b01;
        wait_edges(12);
        checks++; if ({s2, s1} !== 2'b01) begin failures++; $display("FAIL glitch_pair got=%b exp=01", {s2, s1}); end
        checks++; if (valido !== 1'b1) begin failures++; $display("FAIL glitch_valido got=%b exp=1", valido); end
        checks++; if (alarme !== 1'b0) begin failures++; $display("FAIL glitch_alarme got=%b exp=0", alarme); end
        checks++; if (contador_falhas !== 8'd0) begin failures++; $display("FAIL glitch_cont got=%0d exp=0", contador_falhas); end
    endtask

    task automatic test_impossivel();
        set_raw(2'b10);
        wait_edges(6);
        checks++; if (alarme !== 1'b0) begin failures++; $display("FAIL imp_early_alarme got=%b exp=0", alarme); end
        wait_edges(1);
        checks++; if (alarme !== 1'b1) begin failures++; $display("FAIL imp_alarme got=%b exp=1", alarme); end
        checks++; if (valido !== 1'b0) begin failures++; $display("FAIL imp_valido got=%b exp=0", valido); end
        checks++; if ({s2, s1} !== 2'b01) begin failures++; $display("FAIL imp_hold got=%b exp=01", {s2, s1}); end
        checks++; if (contador_falhas !== 8'd1) begin failures++; $display("FAIL imp_cont got=%0d exp=1", contador_falhas); end
        set_raw(2'b01);
        wait_edges(7);
`ifdef ALARME_TRAVADO_EN
        checks++; if (alarme !== 1'b1) begin failures++; $display("FAIL imp_latched got=%b exp=1", alarme); end
        pulse_ack();
        #1;
`endif
        checks++; if (valido !== 1'b1) begin failures++; $display("FAIL imp_recover_valido got=%b exp=1", valido); end
        checks++; if (alarme !== 1'b0) begin failures++; $display("FAIL imp_recover_alarme got=%b exp=0", alarme); end
    endtask

    task automatic test_jump();
        do_reset(2'b00);
        wait_edges(7);
        checks++; if (valido !== 1'b1) begin failures++; $display("FAIL jump_start_valido got=%b exp=1", valido); end
        set_raw(2'b11);
        wait_edges(7);
        checks++; if (alarme !== 1'b1) begin failures++; $display("FAIL jump_alarme got=%b exp=1", alarme); end
        checks++; if (valido !== 1'b0) begin failures++; $display("FAIL jump_valido got=%b exp=0", valido); end
        checks++; if ({s2, s1} !== 2'b00) begin failures++; $display("FAIL jump_hold got=%b exp=00", {s2, s1}); end
        checks++; if (contador_falhas !== 8'd1) begin failures++; $display("FAIL jump_cont got=%0d exp=1", contador_falhas); end
        set_raw(2'b01);
        wait_edges(7);
`ifdef ALARME_TRAVADO_EN
        pulse_ack();
        #1;
`endif
        checks++; if (valido !== 1'b1) begin failures++; $display("FAIL jump_mid_valido got=%b exp=1", valido); end
        checks++; if ({s2, s1} !== 2'b01) begin failures++; $display("FAIL jump_mid_pair got=%b exp=01", {s2, s1}); end
        set_raw(2'b11);
        wait_edges(7);
        checks++; if (valido !== 1'b1) begin failures++; $display("FAIL jump_end_valido got=%b exp=1", valido); end
        checks++; if ({s2, s1} !== 2'b11) begin failures++; $display("FAIL jump_end_pair got=%b exp=11", {s2, s1}); end
        checks++; if (alarme !== 1'b0) begin failures++; $display("FAIL jump_end_alarme got=%b exp=0", alarme); end
    endtask

    task automatic test_init_fault();
        do_reset(2'b10);
        wait_edges(7);
        checks++; if (alarme !== 1'b1) begin failures++; $display("FAIL init_alarme got=%b exp=1", alarme); end
        checks++; if (valido !== 1'b0) begin failures++; $display("FAIL init_valido got=%b exp=0", valido); end
        checks++; if ({s2, s1} !== 2'b00) begin failures++; $display("FAIL init_pair got=%b exp=00", {s2, s1}); end
        checks++; if (contador_falhas !== 8'd0) begin failures++; $display("FAIL init_cont got=%0d exp=0", contador_falhas); end
    endtask

    task automatic test_saturation();
        do_reset(2'b01);
        wait_edges(7);
        for (int i = 0; i < 258; i++) begin
            set_raw(2'b10);
            wait_edges(7);
            set_raw(2'b01);
            wait_edges(7);
`ifdef ALARME_TRAVADO_EN
            pulse_ack();
`endif
            if (i == 253) begin
                checks++; if (contador_falhas !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d exp=254", contador_falhas); end
            end
        end
        #1;
        checks++; if (contador_falhas !== 8'hFF) begin failures++; $display("FAIL sat_cont got=%0d exp=255", contador_falhas); end
        checks++; if (valido !== 1'b1) begin failures++; $display("FAIL sat_valido got=%b exp=1", valido); end
        set_raw(2'b10);
        wait_edges(3);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (contador_falhas !== 8'd0) begin failures++; $display("FAIL async_cont got=%0d exp=0", contador_falhas); end
        checks++; if (valido !== 1'b0) begin failures++; $display("FAIL async_valido got=%b exp=0", valido); end
        checks++; if ({s2, s1} !== 2'b00) begin failures++; $display("FAIL async_pair got=%b exp=00", {s2, s1}); end
        checks++; if (alarme !== 1'b0) begin failures++; $display("FAIL async_alarme got=%b exp=0", alarme); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_glitch();
        test_impossivel();
        test_jump();
        test_init_fault();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
